// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer, ALU and display logic:
// opcodes, FSM state encodings and instruction field positions.
package seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int MODE_BIT = 7;
  localparam int OPC_MSB  = 6;
  localparam int OPC_LSB  = 4;
  localparam int RA_MSB   = 3;
  localparam int RA_LSB   = 2;
  localparam int RB_MSB   = 1;
  localparam int RB_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  function automatic logic [2:0] instr_opcode(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] instr_ra(input logic [7:0] instr);
    return instr[RA_MSB:RA_LSB];
  endfunction

  function automatic logic [1:0] instr_rb(input logic [7:0] instr);
    return instr[RB_MSB:RB_LSB];
  endfunction

  // Mode 1 is reserved, as are opcodes 100..110.
  function automatic logic instr_legal(input logic [7:0] instr);
    logic [2:0] opc;
    opc = instr_opcode(instr);
    return !instr[MODE_BIT] &&
           (opc == OP_NOP || opc == OP_ADD || opc == OP_SUB ||
            opc == OP_INC || opc == OP_HALT);
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// 4-entry register file: one synchronous write port, synchronous active-low
// clear, two combinational read ports and all four entries exported.
module seq_regfile #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          clr_n,
  input  logic          we,
  input  logic [1:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    raddr_a,
  input  logic [1:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3
);

  logic [DW-1:0] regs_q [4];

  always_ff @(posedge clock) begin
    if (!clr_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign r0 = regs_q[0];
  assign r1 = regs_q[1];
  assign r2 = regs_q[2];
  assign r3 = regs_q[3];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller driving an external
// ALU over a start/done handshake and owning a 4-entry register file.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem_req high, waiting for imem_valid
// DECODE | classify IR; launch ALU, skip, or halt
// EXEC   | ALU running; timeout down-counter active
// WB     | write result buffer into R[ra]
// HALT   | parked until reset
// ERROR  | ALU timeout; parked until reset, registers frozen
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [7:0]    imem_data,
  output logic          alu_start,
  output logic [2:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result,
  output logic [DW-1:0] r0_out,
  output logic [DW-1:0] r1_out,
  output logic [DW-1:0] r2_out,
  output logic [DW-1:0] r3_out,
  output logic [2:0]    state_out,
  output logic          halted,
  output logic          error
);

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [7:0]    ir_q;
  logic          req_q;
  logic          start_q;
  logic [2:0]    opc_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] wb_q;
  logic [7:0]    tmo_q;
  logic          halted_q;
  logic          error_q;

  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          rf_we;

  assign rf_we = (state_q == S_WB);

  seq_regfile #(.DW(DW)) u_regfile (
    .clock   (clock),
    .clr_n   (resetn),
    .we      (rf_we),
    .waddr   (instr_ra(ir_q)),
    .wdata   (wb_q),
    .raddr_a (instr_ra(ir_q)),
    .raddr_b (instr_rb(ir_q)),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .r0      (r0_out),
    .r1      (r1_out),
    .r2      (r2_out),
    .r3      (r3_out)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      req_q    <= 1'b0;
      start_q  <= 1'b0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wb_q     <= '0;
      tmo_q    <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            pc_q    <= pc_q + 1'b1;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!instr_legal(ir_q) || instr_opcode(ir_q) == OP_NOP) begin
            if (!instr_legal(ir_q)) error_q <= 1'b1;
            state_q <= run ? S_FETCH : S_IDLE;
            req_q   <= run;
          end else if (instr_opcode(ir_q) == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            a_q     <= rd_a;
            b_q     <= rd_b;
            opc_q   <= instr_opcode(ir_q);
            start_q <= 1'b1;
            tmo_q   <= TMO_LOAD;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Counter reaching zero marks the last of TIMEOUT waiting cycles.
          if (alu_done) begin
            wb_q    <= alu_result;
            state_q <= S_WB;
          end else if (tmo_q == 8'd0) begin
            error_q <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_q - 8'd1;
          end
        end
        S_WB: begin
          state_q <= run ? S_FETCH : S_IDLE;
          req_q   <= run;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign alu_start  = start_q;
  assign alu_opcode = opc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign state_out  = state_q;
  assign halted     = halted_q;
  assign error      = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a one-cycle instruction memory and
// a one-cycle ALU responder.
module tb_instr_sequencer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [7:0]    imem_data = 8'h00;
  logic          alu_start;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_done = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] r0_out, r1_out, r2_out, r3_out;
  logic [2:0]    state_out;
  logic          halted;
  logic          error;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [16];
  logic mem_en = 1'b1;
  logic fetch_wait = 1'b0;
  logic alu_en = 1'b1;
  logic alu_pend = 1'b0;

  instr_sequencer #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .alu_start  (alu_start),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .r0_out     (r0_out),
    .r1_out     (r1_out),
    .r2_out     (r2_out),
    .r3_out     (r3_out),
    .state_out  (state_out),
    .halted     (halted),
    .error      (error)
  );

  always #5 clock = ~clock;

  // Instruction memory: answers a request one cycle after it is raised.
  always @(posedge clock) begin
    #1;
    if (mem_en) begin
      if (imem_req && !imem_valid) begin
        if (fetch_wait) begin
          imem_valid = 1'b1;
          imem_data  = mem[imem_addr];
          fetch_wait = 1'b0;
        end else begin
          fetch_wait = 1'b1;
        end
      end else begin
        imem_valid = 1'b0;
        fetch_wait = 1'b0;
      end
    end
  end

  // ALU: done one cycle after start; alu_en=0 models a hung ALU.
  always @(posedge clock) begin
    #1;
    alu_done = 1'b0;
    if (alu_pend && alu_en) begin
      alu_done = 1'b1;
      case (alu_opcode)
        3'b001:  alu_result = alu_a + alu_b;
        3'b010:  alu_result = alu_a - alu_b;
        3'b011:  alu_result = alu_a + 1;
        default: alu_result = '0;
      endcase
    end
    alu_pend = alu_start;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    run = 1'b0;
    resetn = 1'b0;
    alu_en = 1'b1;
    mem_en = 1'b1;
    imem_valid = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    load_nops();
    do_reset();
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
    total++; if (imem_addr !== 4'd0) begin bad++; $display("FAIL reset_pc: got %0d expected 0", imem_addr); end
    total++; if ({error, halted, alu_start} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {error, halted, alu_start}); end
    total++; if ((r0_out | r1_out | r2_out | r3_out) !== '0) begin bad++; $display("FAIL reset_regs: got nonzero expected 0"); end
  endtask

  task automatic test_program();
    logic seen;
    load_nops();
    mem[0] = 8'h30; mem[1] = 8'h30; mem[2] = 8'h10; mem[3] = 8'h35; mem[4] = 8'h70;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 100 && r0_out !== 32'd4; i++) @(negedge clock);
    total++; if (r0_out !== 32'd4) begin bad++; $display("FAIL prog_r0: got %0d expected 4", r0_out); end
    total++; if (imem_addr !== 4'd3 || imem_req !== 1'b1) begin bad++; $display("FAIL prog_pc: got addr %0d req %0b expected addr 3 req 1", imem_addr, imem_req); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL prog_err: got %0b expected 0", error); end
    for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge clock);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL prog_halted: got %0b expected 1", halted); end
    total++; if (r1_out !== 32'd1) begin bad++; $display("FAIL prog_r1: got %0d expected 1", r1_out); end
    total++; if (state_out !== 3'd5) begin bad++; $display("FAIL prog_state: got %0d expected 5", state_out); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (imem_req === 1'b1 || state_out !== 3'd5) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL halt_hold: got activity 1 expected 0"); end
    total++; if (r0_out !== 32'd4) begin bad++; $display("FAIL halt_r0: got %0d expected 4", r0_out); end
  endtask

  task automatic test_illegal();
    load_nops();
    mem[0] = 8'h40; mem[1] = 8'h30; mem[2] = 8'h70;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 50 && error !== 1'b1; i++) @(negedge clock);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL illegal_err: got %0b expected 1", error); end
    total++; if (state_out !== 3'd1 || imem_addr !== 4'd1) begin bad++; $display("FAIL illegal_skip: got state %0d addr %0d expected state 1 addr 1", state_out, imem_addr); end
    for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge clock);
    total++; if (r0_out !== 32'd1) begin bad++; $display("FAIL illegal_next: got %0d expected 1", r0_out); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL illegal_sticky: got %0b expected 1", error); end
  endtask

  task automatic test_timeout();
    int n;
    load_nops();
    mem[0] = 8'h30; mem[1] = 8'h35; mem[2] = 8'h70;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 100 && r0_out !== 32'd1; i++) @(negedge clock);
    alu_en = 1'b0;
    for (int i = 0; i < 50 && alu_start !== 1'b1; i++) @(negedge clock);
    total++; if (alu_start !== 1'b1) begin bad++; $display("FAIL tmo_start: got %0b expected 1", alu_start); end
    n = 0;
    while (state_out !== 3'd6 && n < 40) begin
      @(negedge clock);
      n++;
    end
    total++; if (n !== TIMEOUT) begin bad++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TIMEOUT); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL tmo_err: got %0b expected 1", error); end
    total++; if (r0_out !== 32'd1 || r1_out !== 32'd0) begin bad++; $display("FAIL tmo_regs: got r0 %0d r1 %0d expected r0 1 r1 0", r0_out, r1_out); end
    repeat (5) @(negedge clock);
    total++; if (state_out !== 3'd6) begin bad++; $display("FAIL tmo_stay: got %0d expected 6", state_out); end
    resetn = 1'b0;
    @(negedge clock);
    total++; if (state_out !== 3'd0 || error !== 1'b0) begin bad++; $display("FAIL tmo_reset: got state %0d err %0b expected state 0 err 0", state_out, error); end
    total++; if (r0_out !== 32'd0) begin bad++; $display("FAIL tmo_reset_r0: got %0d expected 0", r0_out); end
    resetn = 1'b1;
    run = 1'b0;
    alu_en = 1'b1;
  endtask

  task automatic test_run_drop();
    logic seen;
    load_nops();
    mem[0] = 8'h3A; mem[1] = 8'h30; mem[2] = 8'h70;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 50 && alu_start !== 1'b1; i++) @(negedge clock);
    run = 1'b0;
    for (int i = 0; i < 20 && state_out !== 3'd0; i++) @(negedge clock);
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL drop_idle: got %0d expected 0", state_out); end
    total++; if (r2_out !== 32'd1) begin bad++; $display("FAIL drop_r2: got %0d expected 1", r2_out); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (imem_req === 1'b1 || state_out !== 3'd0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL drop_quiet: got activity 1 expected 0"); end
    run = 1'b1;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) @(negedge clock);
    total++; if (imem_req !== 1'b1 || imem_addr !== 4'd1) begin bad++; $display("FAIL drop_resume: got req %0b addr %0d expected req 1 addr 1", imem_req, imem_addr); end
    for (int i = 0; i < 100 && halted !== 1'b1; i++) @(negedge clock);
    total++; if (r0_out !== 32'd1) begin bad++; $display("FAIL drop_r0: got %0d expected 1", r0_out); end
  endtask

  task automatic test_pc_wrap();
    logic [AW-1:0] addrs [17];
    int idx;
    load_nops();
    do_reset();
    run = 1'b1;
    idx = 0;
    for (int i = 0; i < 300 && idx < 17; i++) begin
      @(negedge clock);
      if (imem_req === 1'b1 && imem_valid === 1'b1) begin
        addrs[idx] = imem_addr;
        idx++;
      end
    end
    total++; if (idx !== 17) begin bad++; $display("FAIL wrap_count: got %0d expected 17", idx); end
    total++; if (addrs[15] !== 4'd15 || addrs[16] !== 4'd0) begin bad++; $display("FAIL wrap_addr: got %0d then %0d expected 15 then 0", addrs[15], addrs[16]); end
    mem_en = 1'b0;
    imem_valid = 1'b0;
    for (int i = 0; i < 10 && !(imem_req === 1'b1 && state_out === 3'd1); i++) @(negedge clock);
    imem_valid = 1'b1;
    imem_data = 8'h3F;
    resetn = 1'b0;
    @(negedge clock);
    total++; if (state_out !== 3'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL midfetch_state: got state %0d req %0b expected state 0 req 0", state_out, imem_req); end
    total++; if (dut.ir_q !== 8'h00) begin bad++; $display("FAIL midfetch_ir: got %0h expected 0", dut.ir_q); end
    resetn = 1'b1;
    imem_valid = 1'b0;
    @(negedge clock);
    total++; if (state_out !== 3'd1 || imem_addr !== 4'd0) begin bad++; $display("FAIL midfetch_pc: got state %0d addr %0d expected state 1 addr 0", state_out, imem_addr); end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program();
    test_illegal();
    test_timeout();
    test_run_drop();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
